// File: rtl/sm_dot_acc.sv
// sm_dot_acc -- pipelined sign-magnitude dot-product accumulator.
//
// Each accepted beat carries LANES sign-magnitude activation/weight pairs.
// The lane products are turned into two's complement, summed, and added into
// a running accumulator. A beat flagged last closes the vector: the result
// and a sticky overflow flag are presented on a valid/ready output, and the
// accumulator restarts from zero on the same edge.
//
// Pipeline: S0 input register -> S1 lane products -> S2 lane sum -> S3 acc/out.
// A beat accepted at edge t shows up on out_valid after edge t+3.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   clr             synchronous flush of pipeline, accumulator and out_valid
//   in_valid/ready  input handshake; in_last marks the final beat of a vector
//   Amag/Asign      activation magnitudes (lane i at [i*DW +: DW]) and signs
//   Wmag/Wsign      weight magnitudes and signs
//   out_valid/ready output handshake
//   out_data        signed vector result (ACCW bits)
//   out_ovf         an overflow happened somewhere in this vector
module sm_dot_acc #(
  parameter int DW    = 8,
  parameter int LANES = 4,
  parameter int ACCW  = 32,
  parameter int SAT   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   Amag,
  input  logic [LANES-1:0]      Asign,
  input  logic [LANES*DW-1:0]   Wmag,
  input  logic [LANES-1:0]      Wsign,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACCW-1:0]       out_data,
  output logic                  out_ovf
);

  localparam int PW = 2*DW + 1;               // signed product width
  localparam int SW = PW + $clog2(LANES);     // signed lane-sum width

  // S0: registered operands
  logic                s0_valid_q, s0_valid_d, s0_last_q, s0_last_d;
  logic [LANES*DW-1:0] a_mag_q, a_mag_d, w_mag_q, w_mag_d;
  logic [LANES-1:0]    p_neg_q, p_neg_d;
  // S1: signed lane products
  logic                s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [PW-1:0]       lane_p [LANES];
  logic [PW-1:0]       p_q [LANES];
  logic [PW-1:0]       p_d [LANES];
  // S2: lane sum
  logic                s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [SW-1:0]       lane_sum;
  logic [SW-1:0]       s2_sum_q, s2_sum_d;
  // S3: accumulator and output register
  logic [ACCW-1:0]     acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_q, out_valid_d;
  logic [ACCW-1:0]     out_data_q, out_data_d;
  logic                out_ovf_q, out_ovf_d;

  logic                advance;
  logic [ACCW:0]       exact_sum;
  logic                beat_ovf;
  logic [ACCW-1:0]     beat_res;

  // Whole pipeline moves together; it only stops when a result is waiting.
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance && !clr;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

  // Magnitude product, then negate when exactly one operand is negative.
  // A zero magnitude negates to zero, so there is no negative zero.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [2*DW-1:0] mag;
    assign mag = {{DW{1'b0}}, a_mag_q[gi*DW +: DW]} * {{DW{1'b0}}, w_mag_q[gi*DW +: DW]};
    assign lane_p[gi] = p_neg_q[gi] ? ({PW{1'b0}} - {1'b0, mag}) : {1'b0, mag};
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + {{(SW-PW+1){p_q[i][PW-1]}}, p_q[i][PW-2:0]};
    end
  end

  // One extra bit above ACCW catches the exact sum; overflow is the two top
  // bits disagreeing.
  always_comb begin
    exact_sum = {acc_q[ACCW-1], acc_q} + {{(ACCW-SW+2){s2_sum_q[SW-1]}}, s2_sum_q[SW-2:0]};
    beat_ovf  = exact_sum[ACCW] ^ exact_sum[ACCW-1];
    beat_res  = exact_sum[ACCW-1:0];
    if (SAT != 0 && beat_ovf) begin
      beat_res = exact_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end
  end

  always_comb begin
    s0_valid_d  = s0_valid_q;
    s0_last_d   = s0_last_q;
    a_mag_d     = a_mag_q;
    w_mag_d     = w_mag_q;
    p_neg_d     = p_neg_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    for (int i = 0; i < LANES; i++) p_d[i] = p_q[i];
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    s2_sum_d    = s2_sum_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (clr) begin
      // out_data/out_ovf keep their last value; only validity is dropped.
      s0_valid_d  = 1'b0;
      s1_valid_d  = 1'b0;
      s2_valid_d  = 1'b0;
      acc_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (advance) begin
      s0_valid_d = in_valid;
      s0_last_d  = in_last;
      a_mag_d    = Amag;
      w_mag_d    = Wmag;
      p_neg_d    = Asign ^ Wsign;
      s1_valid_d = s0_valid_q;
      s1_last_d  = s0_last_q;
      for (int i = 0; i < LANES; i++) p_d[i] = lane_p[i];
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_sum_d   = lane_sum;
      // Either nothing was waiting or the waiting result is taken this edge.
      out_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          out_data_d  = beat_res;
          out_ovf_d   = ovf_q | beat_ovf;
          out_valid_d = 1'b1;
          acc_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = beat_res;
          ovf_d = ovf_q | beat_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      a_mag_q     <= '0;
      w_mag_q     <= '0;
      p_neg_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) p_q[i] <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_last_q   <= s0_last_d;
      a_mag_q     <= a_mag_d;
      w_mag_q     <= w_mag_d;
      p_neg_q     <= p_neg_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      for (int i = 0; i < LANES; i++) p_q[i] <= p_d[i];
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_sum_q    <= s2_sum_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_sm_dot_acc.sv
// tb_sm_dot_acc -- drives three sm_dot_acc instances (32-bit wrap, 20-bit
// saturate, 20-bit wrap) with identical beats and compares every result
// against an arithmetic model of the vector sums.
module tb_sm_dot_acc;

  localparam int DW = 8;
  localparam int LANES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [LANES*DW-1:0] a_mag = '0;
  logic [LANES*DW-1:0] w_mag = '0;
  logic [LANES-1:0] a_sign = '0;
  logic [LANES-1:0] w_sign = '0;

  logic in_ready0, in_ready1, in_ready2;
  logic out_valid0, out_valid1, out_valid2;
  logic out_ovf0, out_ovf1, out_ovf2;
  logic [31:0] out_data0;
  logic [19:0] out_data1, out_data2;

  always #5 clk = ~clk;

  sm_dot_acc #(.DW(DW), .LANES(LANES), .ACCW(32), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
    .in_last(in_last), .Amag(a_mag), .Asign(a_sign), .Wmag(w_mag), .Wsign(w_sign),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ovf(out_ovf0));
  sm_dot_acc #(.DW(DW), .LANES(LANES), .ACCW(20), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .in_last(in_last), .Amag(a_mag), .Asign(a_sign), .Wmag(w_mag), .Wsign(w_sign),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ovf(out_ovf1));
  sm_dot_acc #(.DW(DW), .LANES(LANES), .ACCW(20), .SAT(0)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .in_last(in_last), .Amag(a_mag), .Asign(a_sign), .Wmag(w_mag), .Wsign(w_sign),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_ovf(out_ovf2));

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic signed [63:0] obs,
                           input logic signed [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0][63:0] d;
    logic [2:0]       o;
  } res_t;

  res_t   exp_q[$];
  longint m_acc [3];
  bit     m_ovf [3];
  int     n_out = 0;
  longint last_d [3];
  bit     last_o [3];
  int     cyc = 0;
  int     last_cyc = 0;
  int     prev_cyc = 0;

  function automatic int cfg_w(input int k);
    return (k == 0) ? 32 : 20;
  endfunction

  function automatic bit cfg_sat(input int k);
    return (k == 1);
  endfunction

  function automatic longint beat_sum();
    longint s = 0;
    longint prod;
    for (int i = 0; i < LANES; i++) begin
      prod = longint'(a_mag[i*DW +: DW]) * longint'(w_mag[i*DW +: DW]);
      if (a_sign[i] ^ w_sign[i]) s = s - prod;
      else s = s + prod;
    end
    return s;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 0;
    end
  endtask

  task automatic model_beat();
    res_t r;
    longint s, t, lim;
    bit o;
    r = '0;
    s = beat_sum();
    for (int k = 0; k < 3; k++) begin
      lim = longint'(1) <<< (cfg_w(k) - 1);
      t = m_acc[k] + s;
      o = 0;
      if (t > lim - 1) begin
        o = 1;
        t = cfg_sat(k) ? lim - 1 : t - 2*lim;
      end else if (t < -lim) begin
        o = 1;
        t = cfg_sat(k) ? -lim : t + 2*lim;
      end
      m_ovf[k] = m_ovf[k] | o;
      if (in_last) begin
        r.d[k] = t;
        r.o[k] = m_ovf[k];
        m_acc[k] = 0;
        m_ovf[k] = 0;
      end else begin
        m_acc[k] = t;
      end
    end
    if (in_last) exp_q.push_back(r);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are sampled mid-cycle, where every input is settled.
  always @(negedge clk) begin
    res_t r;
    if (!rst) begin
      if (out_valid0 && out_ready) begin
        n_out++;
        prev_cyc = last_cyc;
        last_cyc = cyc;
        last_d[0] = longint'($signed(out_data0));
        last_d[1] = longint'($signed(out_data1));
        last_d[2] = longint'($signed(out_data2));
        last_o[0] = out_ovf0;
        last_o[1] = out_ovf1;
        last_o[2] = out_ovf2;
        if (exp_q.size() == 0) begin
          check_val("spurious_out", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check_val("data_w32", $signed(out_data0), $signed(r.d[0]));
          check_val("ovf_w32", out_ovf0, r.o[0]);
          check_val("data_w20sat", $signed(out_data1), $signed(r.d[1]));
          check_val("ovf_w20sat", out_ovf1, r.o[1]);
          check_val("data_w20wrap", $signed(out_data2), $signed(r.d[2]));
          check_val("ovf_w20wrap", out_ovf2, r.o[2]);
          check_val("valid_w20sat", out_valid1, 1);
          check_val("valid_w20wrap", out_valid2, 1);
        end
        $display("out #%0d: w32=%0d/%0d w20sat=%0d/%0d w20wrap=%0d/%0d", n_out,
                 last_d[0], last_o[0], last_d[1], last_o[1], last_d[2], last_o[2]);
      end
      if (clr) model_clear();
      else if (in_valid && in_ready0) model_beat();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_beat(input logic [31:0] am, input logic [3:0] as,
                           input logic [31:0] wm, input logic [3:0] ws, input logic last);
    bit took = 0;
    a_mag = am; a_sign = as; w_mag = wm; w_sign = ws; in_last = last;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !took; n++) begin
      @(negedge clk);
      took = in_ready0;
      @(posedge clk);
      #1;
    end
    if (!took) check_val("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int target);
    for (int n = 0; n < 100 && n_out < target; n++) @(posedge clk);
    #1;
    check_val("out_count", n_out, target);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check_val("drain", exp_q.size(), 0);
  endtask

  bit rand_on = 0;

  initial begin
    int n0;
    model_clear();
    // ---- reset state ----
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_out_valid", out_valid0, 0);
    check_val("rst_out_data", out_data0, 0);
    check_val("rst_out_ovf", out_ovf0, 0);
    check_val("rst_in_ready", in_ready0, 1);

    // ---- single beat, latency ----
    send_beat({8'd255, 8'd0, 8'd5, 8'd3}, 4'b0110, {8'd1, 8'd9, 8'd2, 8'd4}, 4'b1000, 1'b1);
    check_val("lat_e1", out_valid0, 0);
    @(posedge clk); #1;
    check_val("lat_e2", out_valid0, 0);
    @(posedge clk); #1;
    check_val("lat_e3", out_valid0, 0);
    @(posedge clk); #1;
    check_val("lat_valid", out_valid0, 1);
    check_val("single_data", $signed(out_data0), -253);
    check_val("single_ovf", out_ovf0, 0);
    wait_drain();

    // ---- multi-beat, overflow in the 20-bit configs ----
    n0 = n_out;
    repeat (2) send_beat({4{8'hFF}}, 4'b0, {4{8'hFF}}, 4'b0, 1'b0);
    send_beat({4{8'hFF}}, 4'b0, {4{8'hFF}}, 4'b0, 1'b1);
    wait_out(n0 + 1);
    check_val("mb_w32", last_d[0], 780300);
    check_val("mb_w32_ovf", last_o[0], 0);
    check_val("mb_sat", last_d[1], 524287);
    check_val("mb_sat_ovf", last_o[1], 1);
    check_val("mb_wrap", last_d[2], -268276);
    check_val("mb_wrap_ovf", last_o[2], 1);

    // ---- back-to-back vectors: +100 then -7 ----
    n0 = n_out;
    send_beat(32'd10, 4'b0, 32'd5, 4'b0, 1'b0);
    send_beat(32'd10, 4'b0, 32'd5, 4'b0, 1'b1);
    send_beat(32'd7, 4'b1, 32'd1, 4'b0, 1'b1);
    wait_out(n0 + 2);
    check_val("b2b_second", last_d[0], -7);
    check_val("b2b_gap", last_cyc - prev_cyc, 1);

    // ---- backpressure ----
    n0 = n_out;
    out_ready = 1'b0;
    fork
      begin
        for (int v = 0; v < 6; v++)
          send_beat($urandom, 4'($urandom), $urandom, 4'($urandom), 1'b1);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        check_val("bp_in_ready", in_ready0, 0);
        check_val("bp_out_valid", out_valid0, 1);
        out_ready = 1'b1;
      end
    join
    wait_out(n0 + 6);

    // ---- clr mid-vector ----
    wait_drain();
    n0 = n_out;
    send_beat(32'd50, 4'b0, 32'd50, 4'b0, 1'b0);
    send_beat(32'd60, 4'b0, 32'd60, 4'b0, 1'b0);
    a_mag = 32'd70; w_mag = 32'd70; in_last = 1'b1; in_valid = 1'b1; clr = 1'b1;
    #1;
    check_val("clr_in_ready", in_ready0, 0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    send_beat({8'd0, 8'd0, 8'd2, 8'd9}, 4'b0010, {8'd0, 8'd0, 8'd3, 8'd9}, 4'b0, 1'b0);
    send_beat(32'd1, 4'b0, 32'd1, 4'b0, 1'b1);
    wait_out(n0 + 1);
    check_val("clr_next_sum", last_d[0], 76);
    repeat (5) @(posedge clk); #1;
    check_val("clr_no_extra", n_out, n0 + 1);

    // ---- async reset while output is stalled ----
    out_ready = 1'b0;
    send_beat(32'd3, 4'b0, 32'd3, 4'b0, 1'b1);
    for (int n = 0; n < 20 && !out_valid0; n++) begin @(posedge clk); #1; end
    check_val("ar_stalled_valid", out_valid0, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    model_clear();
    #1;
    check_val("ar_out_valid", out_valid0, 0);
    check_val("ar_out_data", out_data0, 0);
    check_val("ar_out_ovf", out_ovf0, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_val("ar_in_ready", in_ready0, 1);
    n0 = n_out;
    out_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    check_val("ar_no_result", n_out, n0);

    // ---- randomized streaming with random backpressure ----
    rand_on = 1;
    fork
      begin
        for (int v = 0; v < 80; v++) begin
          int len = $urandom_range(1, 6);
          bit biased = ($urandom_range(0, 2) == 0);
          bit neg = $urandom_range(0, 1);
          for (int b = 0; b < len; b++) begin
            logic [31:0] am, wm;
            logic [3:0] as, ws;
            am = $urandom; wm = $urandom; as = 4'($urandom); ws = 4'($urandom);
            if (biased) begin
              for (int i = 0; i < LANES; i++) begin
                am[i*DW +: DW] = 8'($urandom_range(200, 255));
                wm[i*DW +: DW] = 8'($urandom_range(200, 255));
              end
              ws = neg ? ~as : as;
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
            #0;
            send_beat(am, as, wm, ws, (b == len - 1));
          end
        end
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
